bresenham_ray_ctrl: RTL and testbench
=====================================

// Module: bresenham_ray_ctrl
// PURPOSE
//  Sequences a Bresenham ray trace from the sensor origin (0,0) to a signed endpoint (dx,dy).
//  Classifies the octant and drives canonical-octant indices (0 <= y_in <= x_in) plus the
//  flip_x/flip_y/flip_identity controls to flip_indices, one cell per accepted handshake.
//  Sits between the scan-point source and the map-update stage of the SLAM pipeline.
// PARAMETERS
//  XW  5  width of dx, cell_x_in (two's complement / unsigned magnitude)
//  YW  4  width of dy, cell_y_in
// PORTS
//  clk            in   1   clock; all logic on rising edge
//  rst            in   1   synchronous reset, active-high
//  start_valid    in   1   endpoint request valid
//  start_ready    out  1   controller idle, request accepted when valid&&ready
//  dx             in   XW  signed endpoint x, sampled on start handshake
//  dy             in   YW  signed endpoint y, sampled on start handshake
//  abort          in   1   drop current ray, return to IDLE
//  cell_valid     out  1   canonical cell presented
//  cell_ready     in   1   downstream accepts cell
//  cell_x_in      out  XW  canonical major-axis index (unsigned)
//  cell_y_in      out  YW  canonical minor-axis index (unsigned)
//  cell_last      out  1   cell is the ray endpoint (occupied cell)
//  flip_x         out  1   major-axis delta negative
//  flip_y         out  1   minor-axis delta negative
//  flip_identity  out  1   |dy| > |dx|: axes swapped
//  busy           out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 during rst; start_ready=1 from first cycle after rst low.
//  FSM IDLE -> SETUP -> STEP -> IDLE.
//   IDLE: start_ready=1; on start_valid latch dx,dy -> SETUP.
//   SETUP (1 cycle): ax=|dx|, ay=|dy| (XW+1-bit arith; -16 -> 16 fits XW unsigned).
//    flip_identity=(ay>ax); u=major mag, v=minor mag; flip_x=sign(major delta),
//    flip_y=sign(minor delta) (swap: flip_x=dy<0, flip_y=dx<0). x=0,y=0, err=2v-u
//    (signed, XW+3 bits). Flip outputs registered here, constant until next SETUP.
//   STEP: cell_valid=1, cell_x_in=x, cell_y_in=y, cell_last=(x==u).
//    On cell_valid&&cell_ready: if last -> IDLE (cell_valid=0 next cycle); else x<=x+1;
//    if err>0 {y<=y+1; err<=err+2v-2u} else err<=err+2v (tie err==0: no minor step).
//    While valid&&!ready all cell_* and flip_* held stable.
//  Latency: start handshake cycle T -> first cell_valid at T+2; u+1 cells, one per cycle
//   under continuous ready; start_ready back at cycle after last handshake.
//  Zero ray (0,0): one cell (0,0), cell_last=1, flips 000.
//  Ties |dx|==|dy|: flip_identity=0 (diagonal, y steps every cell).
//  abort: highest priority after rst; any state -> IDLE next cycle, cell_valid=0, no last.
//   abort in IDLE with start_valid: request not accepted (start_ready=0 that cycle).
//  rst mid-ray: immediate return to reset values, in-flight ray discarded.
// TESTING
//  (5,2), ready=1 -> (0,0)(1,0)(2,1)(3,1)(4,2)(5,2), last only on (5,2), flips 000, first valid T+2.
//  (-3,7) -> flips fx=0 fy=1 id=1; cells (0,0)(1,0)(2,1)(3,1)(4,2)(5,2)(6,3)(7,3), last on 8th.
//  (-16,0) -> fx=1 fy=0 id=0; 17 cells x_in 0..16, y_in 0; x_in=16 last; (0,0) -> single last cell.
//  (5,2), ready toggled 1,0,0,1... -> outputs stable while stalled; same 6-cell sequence, no drops/dups.
//  abort asserted on 3rd cell of (4,-4) -> cell_valid=0 next cycle, start_ready=1, no last seen;
//   new (2,1) then completes normally.
//  rst pulsed mid-ray of (7,3) -> all outputs 0 during rst, start_ready=1 after, no stale cells.

Source files
------------

// File: rtl/bresenham_ray_ctrl.sv
// Bresenham ray sequencer: walks from the sensor origin to a signed endpoint,
// emitting canonical-octant cell indices plus the flip controls that map them
// back to the real octant. One cell per accepted handshake.
module bresenham_ray_ctrl #(
    parameter int XW = 5,
    parameter int YW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [XW-1:0] dx,
    input  logic [YW-1:0] dy,
    input  logic          abort,
    output logic          cell_valid,
    input  logic          cell_ready,
    output logic [XW-1:0] cell_x_in,
    output logic [YW-1:0] cell_y_in,
    output logic          cell_last,
    output logic          flip_x,
    output logic          flip_y,
    output logic          flip_identity,
    output logic          busy
);

    localparam int EW = XW + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STEP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [XW-1:0]        dx_q;
    logic [YW-1:0]        dy_q;
    logic [XW:0]          u_q;
    logic [XW:0]          v_q;
    logic [XW-1:0]        x_q;
    logic [YW-1:0]        y_q;
    logic signed [EW-1:0] err_q;
    logic                 fx_q;
    logic                 fy_q;
    logic                 fid_q;

    logic                 start_fire;
    logic                 cell_fire;
    logic                 at_last;
    logic                 err_pos;

    logic signed [XW:0]   dx_ext;
    logic signed [YW:0]   dy_ext;
    logic [YW:0]          ay_small;
    logic [XW:0]          ax;
    logic [XW:0]          ay;
    logic [XW:0]          u_w;
    logic [XW:0]          v_w;
    logic                 swap;
    logic signed [EW-1:0] err_init;
    logic signed [EW-1:0] two_v;
    logic signed [EW-1:0] two_u;

    // Handshake qualifiers and step decision terms.
    always_comb begin
        start_fire = start_valid && (state == S_IDLE) && !abort;
        cell_fire  = (state == S_STEP) && cell_ready;
        at_last    = ({1'b0, x_q} == u_q);
        err_pos    = !err_q[EW-1] && (err_q != '0);
        two_v      = EW'({v_q, 1'b0});
        two_u      = EW'({u_q, 1'b0});
    end

    // Octant classification of the latched endpoint; magnitudes use one
    // extra bit so the most negative dx still yields a representable |dx|.
    always_comb begin
        dx_ext   = {dx_q[XW-1], dx_q};
        dy_ext   = {dy_q[YW-1], dy_q};
        ax       = dx_q[XW-1] ? -dx_ext : dx_ext;
        ay_small = dy_q[YW-1] ? -dy_ext : dy_ext;
        ay       = (XW+1)'(ay_small);
        swap     = (ay > ax);
        u_w      = swap ? ay : ax;
        v_w      = swap ? ax : ay;
        err_init = EW'({v_w, 1'b0}) - EW'(u_w);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (start_fire) state_nxt = S_SETUP;
                S_SETUP: state_nxt = S_STEP;
                S_STEP:  if (cell_fire && at_last) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: endpoint latch, octant setup, and the Bresenham walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q  <= '0;
            dy_q  <= '0;
            u_q   <= '0;
            v_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            err_q <= '0;
            fx_q  <= 1'b0;
            fy_q  <= 1'b0;
            fid_q <= 1'b0;
        end else begin
            if (start_fire) begin
                dx_q <= dx;
                dy_q <= dy;
            end
            if (state == S_SETUP && !abort) begin
                u_q   <= u_w;
                v_q   <= v_w;
                x_q   <= '0;
                y_q   <= '0;
                err_q <= err_init;
                fid_q <= swap;
                fx_q  <= swap ? dy_q[YW-1] : dx_q[XW-1];
                fy_q  <= swap ? dx_q[XW-1] : dy_q[YW-1];
            end
            if (cell_fire && !at_last && !abort) begin
                x_q <= x_q + XW'(1);
                if (err_pos) begin
                    y_q   <= y_q + YW'(1);
                    err_q <= err_q + two_v - two_u;
                end else begin
                    err_q <= err_q + two_v;
                end
            end
        end
    end

    // Outputs; everything is forced low while reset is asserted.
    always_comb begin
        start_ready   = 1'b0;
        busy          = 1'b0;
        cell_valid    = 1'b0;
        cell_x_in     = '0;
        cell_y_in     = '0;
        cell_last     = 1'b0;
        flip_x        = 1'b0;
        flip_y        = 1'b0;
        flip_identity = 1'b0;
        if (!rst) begin
            start_ready   = (state == S_IDLE) && !abort;
            busy          = (state != S_IDLE);
            cell_valid    = (state == S_STEP);
            cell_x_in     = x_q;
            cell_y_in     = y_q;
            cell_last     = (state == S_STEP) && at_last;
            flip_x        = fx_q;
            flip_y        = fy_q;
            flip_identity = fid_q;
        end
    end

endmodule

// File: tb/tb_bresenham_ray_ctrl.sv
// Scoreboard bench for bresenham_ray_ctrl: the driver pushes the cells of each
// ray (from a closed-form rounding model) into a queue; the monitor pops and
// compares on every accepted cell.
module tb_bresenham_ray_ctrl;

    localparam int XW = 5;
    localparam int YW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic          abort;
    logic          cell_valid;
    logic          cell_ready;
    logic [XW-1:0] cell_x_in;
    logic [YW-1:0] cell_y_in;
    logic          cell_last;
    logic          flip_x;
    logic          flip_y;
    logic          flip_identity;
    logic          busy;

    always #5 clk = ~clk;

    bresenham_ray_ctrl #(.XW(XW), .YW(YW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .dx           (dx),
        .dy           (dy),
        .abort        (abort),
        .cell_valid   (cell_valid),
        .cell_ready   (cell_ready),
        .cell_x_in    (cell_x_in),
        .cell_y_in    (cell_y_in),
        .cell_last    (cell_last),
        .flip_x       (flip_x),
        .flip_y       (flip_y),
        .flip_identity(flip_identity),
        .busy         (busy)
    );

    int vectors     = 0;
    int miscompares = 0;
    int q[$];
    int pops        = 0;
    int ready_mode  = 0;
    bit idle_pending = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int enc(input int x, input int y, input int last,
                               input int fx, input int fy, input int fid);
        return (x << 8) | (y << 4) | (last << 3) | (fx << 2) | (fy << 1) | fid;
    endfunction

    // Reference: the cell at major index j lies on the line rounded to the
    // nearest minor index, ties rounded down.
    task automatic push_model(input int sdx, input int sdy);
        int ax, ay, u, v, fx, fy, fid, y;
        ax  = (sdx < 0) ? -sdx : sdx;
        ay  = (sdy < 0) ? -sdy : sdy;
        fid = (ay > ax) ? 1 : 0;
        u   = fid ? ay : ax;
        v   = fid ? ax : ay;
        fx  = fid ? (sdy < 0) : (sdx < 0);
        fy  = fid ? (sdx < 0) : (sdy < 0);
        for (int j = 0; j <= u; j++) begin
            y = (u == 0) ? 0 : (2 * j * v + u - 1) / (2 * u);
            q.push_back(enc(j, y, (j == u) ? 1 : 0, fx, fy, fid));
        end
    endtask

    task automatic send(input int sdx, input int sdy);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        start_valid = 1'b1;
        dx          = XW'(sdx);
        dy          = YW'(sdy);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (start_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("start_accept", got, 1);
        if (got) begin
            push_model(sdx, sdy);
            pops = 0;
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        if (got) begin
            @(negedge clk);
            chk("setup_gap", {busy, cell_valid}, 2'b10);
            @(negedge clk);
            chk("first_valid_t2", cell_valid, 1);
        end
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ray_done", ok, 1);
    endtask

    task automatic wait_pops(input int n, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            if (pops >= n) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, got, 1);
    endtask

    // Downstream ready generator.
    initial begin
        int ph = 0;
        cell_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: cell_ready = 1'b1;
                1: begin
                    cell_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                2: cell_ready = 1'($urandom_range(0, 1));
                default: cell_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on accepted cells, checks stall stability and return to idle.
    initial begin
        int act, held, exp;
        bit stalled = 1'b0;
        held = 0;
        forever begin
            @(negedge clk);
            act = int'({cell_x_in, cell_y_in, cell_last, flip_x, flip_y, flip_identity});
            if (rst) begin
                stalled      = 1'b0;
                idle_pending = 1'b0;
            end else begin
                if (idle_pending) begin
                    chk("idle_after_last", {start_ready, cell_valid}, 2'b10);
                    idle_pending = 1'b0;
                end
                if (cell_valid) begin
                    if (stalled) chk("stall_hold", act, held);
                    if (cell_ready && !abort) begin
                        if (q.size() == 0) begin
                            chk("unexpected_cell", act, -1);
                        end else begin
                            exp = q.pop_front();
                            chk("cell", act, exp);
                            pops++;
                            if (exp[3]) idle_pending = 1'b1;
                        end
                    end
                end
                stalled = cell_valid && !cell_ready && !abort;
                held    = act;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        abort       = 1'b0;
        dx          = '0;
        dy          = '0;
        ready_mode  = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({start_ready, cell_valid, cell_x_in, cell_y_in, cell_last,
                                   flip_x, flip_y, flip_identity, busy}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {start_ready, busy, cell_valid}, 3'b100);

        // Directed rays under continuous ready.
        send(5, 2);    wait_done();
        send(-3, 7);   wait_done();
        send(-16, 0);  wait_done();
        send(0, 0);    wait_done();

        // Same ray under a 1,0,0 ready pattern.
        ready_mode = 1;
        send(5, 2);    wait_done();

        // Abort while the third cell of (4,-4) is presented.
        ready_mode = 0;
        send(4, -4);
        wait_pops(2, "abort_reach_3rd");
        ready_mode = 3;
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        q.delete();
        @(negedge clk);
        chk("abort_outputs", {cell_valid, start_ready, busy}, 3'b010);
        chk("abort_pops", pops, 2);
        ready_mode = 0;
        send(2, 1);    wait_done();

        // Abort in IDLE blocks a concurrent start request.
        @(posedge clk);
        #1;
        abort       = 1'b1;
        start_valid = 1'b1;
        dx          = XW'(3);
        dy          = YW'(1);
        @(negedge clk);
        chk("abort_idle_ready", start_ready, 0);
        @(posedge clk);
        #1;
        abort       = 1'b0;
        start_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);

        // Reset pulsed in the middle of (7,3).
        send(7, 3);
        wait_pops(3, "rst_reach_4th");
        #1;
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("rst_mid_outputs", int'({start_ready, cell_valid, cell_x_in, cell_y_in, cell_last,
                                     flip_x, flip_y, flip_identity, busy}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_after", {start_ready, busy, cell_valid}, 3'b100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale_cell", cell_valid, 0);
        end

        // Random endpoints with random ready behaviour.
        for (int n = 0; n < 40; n++) begin
            int rdx, rdy;
            rdx        = int'($urandom_range(0, 31)) - 16;
            rdy        = int'($urandom_range(0, 15)) - 8;
            ready_mode = int'($urandom_range(0, 2));
            send(rdx, rdy);
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
